cache_axi_arbiter: RTL

- Shares one sram-like memory port (to the AXI bridge) between the instruction-cache and data-cache miss/write-back ports.
- Sits between both caches and the sram-to-AXI interface.
- One transaction outstanding at a time; handshakes are locked per transaction.
- Routes data_ok and rdata back to the master that owns the transaction.

---
 rtl/cache_axi_arbiter_pkg.sv | 14 +
 rtl/cache_axi_arbiter_rr2.sv | 52 +++++
 rtl/cache_axi_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types for the cache-to-AXI-bridge arbiter.
// State encoding and port identifiers.
package cache_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2
    } arb_state_e;

    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/cache_axi_arbiter_rr2.sv
// Two-input grant: fixed data priority or round-robin.
// Keeps the last granted port for tie-breaking.
module arb_rr2
    import cache_axi_arbiter_pkg::*;
#(
    parameter int DATA_PRIORITY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       winner_i,
    output logic       gnt_valid_o,
    output logic       gnt_o
);

    logic last_q;
    logic last_d;

    // Next value of the last-grant record.
    always_comb begin
        last_d = last_q;
        if (update_i) begin
            last_d = winner_i;
        end
    end

    // Last-grant register, reset to the inst port so data wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_INST;
        end else begin
            last_q <= last_d;
        end
    end

    // Pick a winner; ties go to data or to the port not served last.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_o       = PORT_INST;
        if (req_i[1] && !req_i[0]) begin
            gnt_o = PORT_DATA;
        end else if (req_i[1] && req_i[0]) begin
            if (DATA_PRIORITY != 0) begin
                gnt_o = PORT_DATA;
            end else begin
                gnt_o = ~last_q;
            end
        end
    end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one sram-like memory port between i-cache and d-cache.
// One transaction in flight; responses routed to the owner.
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter int DATA_PRIORITY = 1,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [1:0]            inst_size,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [31:0]           inst_wdata,
    output logic [31:0]           inst_rdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           data_wdata,
    output logic [31:0]           data_rdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    output logic                  owner,
    output logic                  busy
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       gnt_valid;
    logic       gnt;
    logic       upd;
    logic       sel;
    logic       addr_ok;
    logic       data_ok;

    arb_rr2 #(
        .DATA_PRIORITY(DATA_PRIORITY)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      ({data_req, inst_req}),
        .update_i   (upd),
        .winner_i   (owner_d),
        .gnt_valid_o(gnt_valid),
        .gnt_o      (gnt)
    );

    // Transaction FSM: grant in IDLE, hold owner through ADDR and WAIT.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        upd     = 1'b0;
        sel     = owner_q;
        mem_req = 1'b0;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    sel     = gnt;
                    owner_d = gnt;
                    mem_req = 1'b1;
                    if (mem_addr_ok) begin
                        addr_ok = 1'b1;
                        upd     = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (owner_q ? data_req : inst_req) begin
                    mem_req = 1'b1;
                    if (mem_addr_ok) begin
                        addr_ok = 1'b1;
                        upd     = 1'b1;
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_data_ok) begin
                    data_ok = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Forward the selected port to memory and route handshakes back.
    always_comb begin
        mem_wr       = 1'b0;
        mem_size     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (mem_req) begin
            mem_wr    = sel ? data_wr    : inst_wr;
            mem_size  = sel ? data_size  : inst_size;
            mem_addr  = sel ? data_addr  : inst_addr;
            mem_wdata = sel ? data_wdata : inst_wdata;
        end
        inst_addr_ok = addr_ok && (owner_d == PORT_INST);
        data_addr_ok = addr_ok && (owner_d == PORT_DATA);
        inst_data_ok = data_ok && (owner_q == PORT_INST);
        data_data_ok = data_ok && (owner_q == PORT_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        owner        = owner_q;
        busy         = (state_q != S_IDLE);
    end

    // State and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= PORT_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule
